// File: rtl/alu_issue.sv
// alu_issue: request-side sequencer for the combinational ALU.
//
// Accepts one operation at a time over a valid/ready request channel. It
// registers the operands, drives them to the ALU and captures the ALU result.
// It then returns the result over a valid/ready response channel.
// Divide-by-zero on div/mod is resolved here without the ALU and is flagged
// on rsp_dbz. Division by zero returns all-ones. Modulo by zero returns lhs.
//
// Build option: when the macro ALU_ITERDIV_EN is defined, a non-zero div/mod
// is computed by an internal W-cycle restoring divider instead of the ALU.
// When the macro is undefined, no divider logic is built.
//
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where valid && ready are both high. A valid source holds its payload
// stable until that edge. ready may be asserted independently of valid.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake
//   req_op/req_lhs/req_rhs        opcode and unsigned operands
//   alu_op/alu_lhs/alu_rhs        registered operands to the ALU
//   alu_result                    combinational result from the ALU
//   rsp_valid/rsp_ready           response handshake
//   rsp_result/rsp_dbz            result and divide-by-zero flag
//   dbg_state                     current FSM state (IDLE=0 EXEC=1 DIV=2 RESP=3)
module alu_issue #(
  parameter int CELL_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [CELL_SIZE-1:0] req_lhs,
  input  logic [CELL_SIZE-1:0] req_rhs,
  output logic [2:0]           alu_op,
  output logic [CELL_SIZE-1:0] alu_lhs,
  output logic [CELL_SIZE-1:0] alu_rhs,
  input  logic [CELL_SIZE-1:0] alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CELL_SIZE-1:0] rsp_result,
  output logic                 rsp_dbz,
  output logic [1:0]           dbg_state
);

  localparam int W = CELL_SIZE;

  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DIV  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [2:0]   r_op;
  logic [W-1:0] r_lhs;
  logic [W-1:0] r_rhs;
  logic [W-1:0] r_result;
  logic         r_dbz;

  logic w_accept;
  logic w_is_divmod;
  logic w_dbz;

  assign w_accept    = req_valid && (r_state == S_IDLE);
  assign w_is_divmod = (req_op == OP_DIV) || (req_op == OP_MOD);
  assign w_dbz       = w_is_divmod && (req_rhs == '0);

`ifdef ALU_ITERDIV_EN
  localparam int CW = $clog2(W + 1);

  logic [W:0]    r_rem;
  logic [W-1:0]  r_quo;
  logic [CW-1:0] r_cnt;

  // One restoring step: shift {rem, quo} left by one and subtract rhs when it fits.
  // The shifted value is widened by a bit so that the compare sees every bit of r_rem.
  logic [W+1:0] w_shift;
  logic [W:0]   w_diff;
  logic         w_ge;
  logic [W:0]   w_rem_next;
  logic [W-1:0] w_quo_next;
  logic         w_div_last;

  assign w_shift    = {r_rem, r_quo[W-1]};
  assign w_ge       = (w_shift >= {2'b00, r_rhs});
  assign w_diff     = w_shift[W:0] - {1'b0, r_rhs};
  assign w_rem_next = w_ge ? w_diff : w_shift[W:0];
  assign w_quo_next = {r_quo[W-2:0], w_ge};
  assign w_div_last = (r_cnt == CW'(W - 1));
`endif

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_dbz) begin
            w_next_state = S_RESP;
`ifdef ALU_ITERDIV_EN
          end else if (w_is_divmod) begin
            w_next_state = S_DIV;
`endif
          end else begin
            w_next_state = S_EXEC;
          end
        end
      end
      S_EXEC: w_next_state = S_RESP;
      S_DIV: begin
`ifdef ALU_ITERDIV_EN
        if (w_div_last) begin
          w_next_state = S_RESP;
        end
`else
        w_next_state = S_IDLE;
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_lhs    <= '0;
      r_rhs    <= '0;
      r_result <= '0;
      r_dbz    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= req_op;
        r_lhs <= req_lhs;
        r_rhs <= req_rhs;
        if (w_dbz) begin
          r_result <= (req_op == OP_DIV) ? {W{1'b1}} : req_lhs;
          r_dbz    <= 1'b1;
        end
      end
      if (r_state == S_EXEC) begin
        r_result <= alu_result;
        r_dbz    <= 1'b0;
      end
`ifdef ALU_ITERDIV_EN
      if ((r_state == S_DIV) && w_div_last) begin
        r_result <= (r_op == OP_DIV) ? w_quo_next : w_rem_next[W-1:0];
        r_dbz    <= 1'b0;
      end
`endif
    end
  end

`ifdef ALU_ITERDIV_EN
  // Divider registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_quo <= '0;
      r_cnt <= '0;
    end else if (w_accept && w_is_divmod && !w_dbz) begin
      r_rem <= '0;
      r_quo <= req_lhs;
      r_cnt <= '0;
    end else if (r_state == S_DIV) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      r_cnt <= r_cnt + CW'(1);
    end
  end
`endif

  assign req_ready  = (r_state == S_IDLE);
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_result = r_result;
  assign rsp_dbz    = r_dbz;
  assign alu_op     = r_op;
  assign alu_lhs    = r_lhs;
  assign alu_rhs    = r_rhs;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

  localparam int W = 16;

`ifdef ALU_ITERDIV_EN
  localparam int DIV_CYC   = 17;
  localparam int ABORT_CYC = 5;
`else
  localparam int DIV_CYC   = 2;
  localparam int ABORT_CYC = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] req_lhs;
  logic [W-1:0] req_rhs;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_lhs;
  logic [W-1:0] alu_rhs;
  logic [W-1:0] alu_result;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_dbz;
  logic [1:0]   dbg_state;

  int checks;
  int failures;

  alu_issue #(.CELL_SIZE(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_lhs    (req_lhs),
    .req_rhs    (req_rhs),
    .alu_op     (alu_op),
    .alu_lhs    (alu_lhs),
    .alu_rhs    (alu_rhs),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_dbz    (rsp_dbz),
    .dbg_state  (dbg_state)
  );

  // Stand-in for the combinational ALU instance.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'b000: alu_result = alu_lhs + alu_rhs;
      3'b001: alu_result = alu_lhs - alu_rhs;
      3'b010: alu_result = alu_lhs * alu_rhs;
      3'b011: alu_result = (alu_rhs == '0) ? '1 : alu_lhs / alu_rhs;
      3'b100: alu_result = (alu_rhs == '0) ? alu_lhs : alu_lhs % alu_rhs;
      3'b101: alu_result = alu_lhs & alu_rhs;
      3'b110: alu_result = alu_lhs | alu_rhs;
      default: alu_result = alu_lhs ^ alu_rhs;
    endcase
  end

  // Clock / reset block.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: issue one request, measure the response cycle (accept = cycle 0),
  // optionally hold rsp_ready low for `stall` cycles, then complete the handshake.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] l,
                       input logic [W-1:0] r, input logic [W-1:0] exp_res,
                       input logic exp_dbz, input int exp_cyc, input int stall);
    int cyc;
    @(negedge clk);
    rsp_ready = (stall == 0);
    check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_lhs   = l;
    req_rhs   = r;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check({tag, " alu_op"}, 32'(alu_op), 32'(op));
    check({tag, " alu_lhs"}, 32'(alu_lhs), 32'(l));
    check({tag, " alu_rhs"}, 32'(alu_rhs), 32'(r));
    cyc = 1;
    while (!rsp_valid && cyc < 40) begin
      check({tag, " req_ready busy"}, 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " rsp cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " rsp_result"}, 32'(rsp_result), 32'(exp_res));
    check({tag, " rsp_dbz"}, 32'(rsp_dbz), 32'(exp_dbz));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check({tag, " stall rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " stall rsp_result"}, 32'(rsp_result), 32'(exp_res));
      check({tag, " stall rsp_dbz"}, 32'(rsp_dbz), 32'(exp_dbz));
      check({tag, " stall req_ready"}, 32'(req_ready), 32'd0);
    end
    if (stall > 0) begin
      @(negedge clk);
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, " post rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " post req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int seen;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    req_lhs   = '0;
    req_rhs   = '0;
    rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_result", 32'(rsp_result), 32'd0);
    check("reset rsp_dbz", 32'(rsp_dbz), 32'd0);
    check("reset alu_op", 32'(alu_op), 32'd0);
    check("reset alu_lhs", 32'(alu_lhs), 32'd0);
    check("reset alu_rhs", 32'(alu_rhs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset req_ready", 32'(req_ready), 32'd1);

    do_op("add",     3'b000, 16'h0005, 16'h0003, 16'h0008, 1'b0, 2, 0);
    do_op("sub wrap", 3'b001, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 2, 0);
    do_op("mul wrap", 3'b010, 16'h0100, 16'h0100, 16'h0000, 1'b0, 2, 0);
    do_op("and",     3'b101, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 2, 0);
    do_op("or",      3'b110, 16'hF0F0, 16'h0F01, 16'hFFF1, 1'b0, 2, 0);
    do_op("xor",     3'b111, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0, 2, 0);
    do_op("div 100/7", 3'b011, 16'd100, 16'd7, 16'd14, 1'b0, DIV_CYC, 0);
    do_op("mod 100%7", 3'b100, 16'd100, 16'd7, 16'd2, 1'b0, DIV_CYC, 0);
    do_op("div ffff/1", 3'b011, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, DIV_CYC, 0);
    do_op("mod 8000%8001", 3'b100, 16'h8000, 16'h8001, 16'h8000, 1'b0, DIV_CYC, 0);
    do_op("div 1234/0", 3'b011, 16'h1234, 16'h0000, 16'hFFFF, 1'b1, 1, 0);
    do_op("mod 1234%0", 3'b100, 16'h1234, 16'h0000, 16'h1234, 1'b1, 1, 0);
    do_op("after dbz add", 3'b000, 16'h0001, 16'h0001, 16'h0002, 1'b0, 2, 0);
    do_op("bp mod0", 3'b100, 16'h00AB, 16'h0000, 16'h00AB, 1'b1, 1, 5);
    do_op("bp add", 3'b000, 16'h1234, 16'h1111, 16'h2345, 1'b0, 2, 5);

    // Reset in the middle of an operation.
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_op    = 3'b011;
    req_lhs   = 16'd100;
    req_rhs   = 16'd7;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (ABORT_CYC - 1) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort rsp_result", 32'(rsp_result), 32'd0);
    check("abort rsp_dbz", 32'(rsp_dbz), 32'd0);
    check("abort alu_op", 32'(alu_op), 32'd0);
    check("abort alu_lhs", 32'(alu_lhs), 32'd0);
    check("abort alu_rhs", 32'(alu_rhs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    check("abort no stale rsp", 32'(seen), 32'd0);
    do_op("div after abort", 3'b011, 16'd100, 16'd7, 16'd14, 1'b0, DIV_CYC, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Request-side sequencer for the combinational ALU: accepts one operation at a time over a valid/ready request channel, drives the ALU's `op`/`lhs`/`rhs` inputs from registers, captures the ALU's `result`, and returns it over a valid/ready response channel. Division and modulo are optionally computed by an internal iterative restoring divider rather than the ALU's combinational `/` and `%`. Divide-by-zero is fully defined and flagged. Sits between the datapath control FSM and the ALU instance.

## Interface
- CELL_SIZE, 16, operand/result width W (≥ 2)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  3  ALU opcode: 000 add, 001 sub, 010 mul, 011 div, 100 mod, 101 and, 110 or, 111 xor
- req_lhs  in  W  left operand, unsigned
- req_rhs  in  W  right operand, unsigned
- alu_op  out  3  to ALU `op`
- alu_lhs  out  W  to ALU `lhs`
- alu_rhs  out  W  to ALU `rhs`
- alu_result  in  W  from ALU `result`
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  W  operation result
- rsp_dbz  out  1  divide-by-zero: op is 011/100 and rhs == 0

## Operation
- States: IDLE, EXEC, DIV, RESP. Reset → IDLE.
- req_ready = (state == IDLE). Handshake when req_valid && req_ready: latch op/lhs/rhs into operand registers.
- alu_op/alu_lhs/alu_rhs are driven directly from the operand registers; they hold their last values in all states.
- Transitions out of IDLE on accept:
  - op 011/100 with rhs == 0 → RESP; rsp_result = all-ones (div) or lhs (mod); rsp_dbz = 1.
  - op 011/100 with rhs ≠ 0 and ALU_ITERDIV_EN defined → DIV.
  - otherwise → EXEC.
- EXEC: one cycle; at its end rsp_result ← alu_result, rsp_dbz ← 0, → RESP.
- DIV: restoring division over exactly W cycles. The remainder register is W+1 bits, zeroed on entry. The quotient register is loaded with lhs. Each cycle:
  - shift {rem, quo} left by one.
  - if rem ≥ rhs: rem −= rhs, quo LSB = 1.
  - After the W-th cycle: rsp_result ← quo (div) or rem[W-1:0] (mod), → RESP.
- RESP: rsp_valid = 1. rsp_result and rsp_dbz are held stable until rsp_valid && rsp_ready, then → IDLE.
- Arithmetic: unsigned. Add/sub/mul results are truncated modulo 2^W (the ALU's behaviour, passed through unchanged).
- No request overlap: a new request is accepted only in IDLE, so the earliest next accept is the cycle after the response handshake.
- Reset asserted in any state aborts the operation immediately; no response is produced.

## Timing
- Reset values: req_ready = 1 (after release), rsp_valid = 0, rsp_result = 0, rsp_dbz = 0, alu_op/alu_lhs/alu_rhs = 0, divider registers = 0.
- Accept in cycle 0. Then:
  - Non-divide ops: EXEC in cycle 1, rsp_valid in cycle 2 (latency 2).
  - Divide-by-zero: rsp_valid in cycle 1 (latency 1).
  - Iterative div/mod: DIV in cycles 1..W, rsp_valid in cycle W+1 (latency W+1; 17 for W = 16).
- The ALU path is treated as a single-cycle combinational path from the operand registers to rsp_result.
- rsp_valid never deasserts without a handshake. req_ready is low in every state except IDLE.

## Configuration
- ALU_ITERDIV_EN defined:
  - Non-zero div/mod use the internal W-cycle divider.
  - The result is independent of alu_result.
- ALU_ITERDIV_EN undefined:
  - No divider logic is present; non-zero div/mod go through EXEC like other ops (latency 2, result = alu_result).
  - Divide-by-zero handling is identical in both builds.

## Test plan
- Add: op 000, lhs 0x0005, rhs 0x0003, rsp_ready = 1 → alu_op = 000, rsp_result 0x0008, rsp_dbz 0, rsp_valid in cycle 2.
- Sub wrap: op 001, lhs 0x0000, rhs 0x0001 → 0xFFFF. Mul: op 010, lhs 0x0100, rhs 0x0100 → 0x0000.
- Div/mod, both builds: 100/7 → 14 and 100%7 → 2; 0xFFFF/0x0001 → 0xFFFF; 0x8000%0x8001 → 0x8000. With ALU_ITERDIV_EN the response arrives in cycle 17; without it, in cycle 2.
- Divide-by-zero: lhs 0x1234, rhs 0 → div gives 0xFFFF and mod gives 0x1234, rsp_dbz 1, response in cycle 1; the next request gives rsp_dbz 0.
- Backpressure: rsp_ready held low for 5 cycles after rsp_valid → rsp_valid, rsp_result and rsp_dbz stable, req_ready 0 throughout; rsp_ready high → handshake, req_ready 1 in the next cycle.
- Reset mid-divide: rst_n low during cycle 5 of DIV → all outputs at reset values immediately; after release, a fresh 100/7 returns 14 and no stale response appears.
